dmem_responder: RTL and testbench

Data-memory responder for the 5-stage pipeline: the memory-side end of the MA-stage load/store interface. It accepts one load or store request at a time from the memory-access stage over a valid/ready handshake. It models a fixed-latency word-addressed RAM with programmable wait states, and returns load data or a store acknowledgement over a second valid/ready handshake.

---
 rtl/dmem_responder.sv | 179 +++++++++++++++++
 tb/tb_dmem_responder.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
// Memory-side end of the MA-stage load/store interface. It accepts one
// load/store request at a time over a valid/ready handshake, models a
// word-addressed RAM with WAIT_CYCLES programmable wait states, and returns
// load data or a store acknowledgement over a second valid/ready handshake.
//
// Parameters:
//   ADDR_W       word-address bits (memory depth 2^ADDR_W 32-bit words)
//   WAIT_CYCLES  wait states between acceptance and response (0..15)
//
// Ports:
//   clock, reset             sole clock; synchronous active-high reset
//   req_valid / req_ready    request handshake
//   req_isLd, req_isSt       request class
//   req_addr, req_wdata      byte address and store data
//   rsp_valid / rsp_ready    response handshake
//   rsp_ldResult             load data (0 for stores, no-ops and errors)
//   rsp_isSt                 response acknowledges a store
//   rsp_error                request faulted, no memory effect
//   busy                     responder is in WAIT or RESP
//
// Optional feature: define DMEM_ERR_CHECK_EN to fault misaligned addresses
// and addresses beyond the memory depth. Without it the low two address
// bits are ignored and the word index wraps modulo the memory depth.

module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_isLd,
  input  logic        req_isSt,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_ldResult,
  output logic        rsp_isSt,
  output logic        rsp_error,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  stateT              r_state;
  logic [3:0]         r_count;
  logic [ADDR_W-1:0]  r_idx;
  logic [31:0]        r_wdata;
  logic               r_isLd;
  logic               r_isSt;
  logic               r_err;
  logic               r_rspValid;
  logic [31:0]        r_ldResult;
  logic               r_rspIsSt;
  logic               r_rspError;
  logic [31:0]        r_mem [2**ADDR_W];

  logic [ADDR_W-1:0]  w_reqIdx;
  logic               w_reqErr;
  logic               w_fromIdle;
  logic [ADDR_W-1:0]  w_srcIdx;
  logic [31:0]        w_srcWdata;
  logic               w_srcLd;
  logic               w_srcSt;
  logic               w_srcErr;
  logic               w_enterResp;
  logic               w_doWrite;
  logic [31:0]        w_loadData;

  assign w_reqIdx = req_addr[ADDR_W+1:2];

  // The fault decision is made at acceptance time so that only the word
  // index has to be held while waiting.
`ifdef DMEM_ERR_CHECK_EN
  assign w_reqErr = (req_isLd && req_isSt)
                  || (req_addr[1:0] != 2'b00)
                  || (req_addr[31:ADDR_W+2] != '0);
`else
  logic [31-ADDR_W:0] w_unusedAddrBits;
  assign w_unusedAddrBits = {req_addr[31:ADDR_W+2], req_addr[1:0]};
  assign w_reqErr = req_isLd && req_isSt;
`endif

  // With zero wait states the memory access happens on the acceptance edge
  // itself, so the live request inputs stand in for the captured copies.
  assign w_fromIdle = (r_state == IDLE);
  assign w_srcIdx   = w_fromIdle ? w_reqIdx  : r_idx;
  assign w_srcWdata = w_fromIdle ? req_wdata : r_wdata;
  assign w_srcLd    = w_fromIdle ? req_isLd  : r_isLd;
  assign w_srcSt    = w_fromIdle ? req_isSt  : r_isSt;
  assign w_srcErr   = w_fromIdle ? w_reqErr  : r_err;

  assign w_enterResp = (w_fromIdle && req_valid && ZERO_WAIT)
                     || (r_state == WAIT && r_count == 4'd0);
  assign w_doWrite   = w_enterResp && w_srcSt && !w_srcLd && !w_srcErr;
  assign w_loadData  = (w_srcLd && !w_srcSt && !w_srcErr) ? r_mem[w_srcIdx] : 32'd0;

  // Memory array: never reset; a reset on the access edge suppresses the write.
  always_ff @(posedge clock) begin
    if (!reset && w_doWrite) begin
      r_mem[w_srcIdx] <= w_srcWdata;
    end
  end

  // Request/response sequencer: capture in IDLE, count wait states in WAIT,
  // hold the registered response in RESP until the consumer takes it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_count    <= 4'd0;
      r_idx      <= '0;
      r_wdata    <= 32'd0;
      r_isLd     <= 1'b0;
      r_isSt     <= 1'b0;
      r_err      <= 1'b0;
      r_rspValid <= 1'b0;
      r_ldResult <= 32'd0;
      r_rspIsSt  <= 1'b0;
      r_rspError <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_idx   <= w_reqIdx;
            r_wdata <= req_wdata;
            r_isLd  <= req_isLd;
            r_isSt  <= req_isSt;
            r_err   <= w_reqErr;
            if (ZERO_WAIT) begin
              r_state <= RESP;
            end else begin
              r_count <= WAIT_LOAD;
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (r_count == 4'd0) begin
            r_state <= RESP;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state    <= IDLE;
            r_rspValid <= 1'b0;
            r_ldResult <= 32'd0;
            r_rspIsSt  <= 1'b0;
            r_rspError <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase

      // A faulted store is not acknowledged as a store.
      if (w_enterResp) begin
        r_rspValid <= 1'b1;
        r_ldResult <= w_loadData;
        r_rspIsSt  <= w_srcSt && !w_srcErr;
        r_rspError <= w_srcErr;
      end
    end
  end

  assign req_ready    = (r_state == IDLE) && !reset;
  assign busy         = (r_state != IDLE);
  assign rsp_valid    = r_rspValid;
  assign rsp_ldResult = r_ldResult;
  assign rsp_isSt     = r_rspIsSt;
  assign rsp_error    = r_rspError;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Self-checking bench for dmem_responder. A WAIT_CYCLES=2 instance carries
// the directed table, the stall/reset sequences and a randomized run against
// a word-array reference model; a WAIT_CYCLES=0 instance covers the
// zero-wait latency and back-to-back acceptance rate.
// Honours DMEM_ERR_CHECK_EN for the expected fault behaviour.

module tb_dmem_responder;

  localparam int ADDR_W = 10;
  localparam int WAITC  = 2;
`ifdef DMEM_ERR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        reqValid, reqReady, reqIsLd, reqIsSt;
  logic [31:0] reqAddr, reqWdata;
  logic        rspValid, rspReady, rspIsSt, rspError, busy;
  logic [31:0] rspLdResult;

  logic        zReqValid, zReqReady, zReqIsLd, zReqIsSt;
  logic [31:0] zReqAddr, zReqWdata;
  logic        zRspValid, zRspReady, zRspIsSt, zRspError, zBusy;
  logic [31:0] zRspLdResult;

  int nCompared = 0;
  int nMismatch = 0;

  logic [31:0] modelMem [int];

  dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAITC)) dut (
    .clock(clock), .reset(reset),
    .req_valid(reqValid), .req_ready(reqReady),
    .req_isLd(reqIsLd), .req_isSt(reqIsSt),
    .req_addr(reqAddr), .req_wdata(reqWdata),
    .rsp_valid(rspValid), .rsp_ready(rspReady),
    .rsp_ldResult(rspLdResult), .rsp_isSt(rspIsSt),
    .rsp_error(rspError), .busy(busy)
  );

  dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dutZero (
    .clock(clock), .reset(reset),
    .req_valid(zReqValid), .req_ready(zReqReady),
    .req_isLd(zReqIsLd), .req_isSt(zReqIsSt),
    .req_addr(zReqAddr), .req_wdata(zReqWdata),
    .rsp_valid(zRspValid), .rsp_ready(zRspReady),
    .rsp_ldResult(zRspLdResult), .rsp_isSt(zRspIsSt),
    .rsp_error(zRspError), .busy(zBusy)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  // Hard stop in case a sequence wedges outside the bounded waits.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: actual=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference behaviour from the request rules: fault classification,
  // word index modulo depth, and a word array for contents.
  task automatic modelReq(input logic isLd, input logic isSt, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] eLd,
                          output logic eIsSt, output logic eErr);
    bit misaligned = (addr % 4) != 0;
    bit outOfRange = (addr / 4) >= (1 << ADDR_W);
    int word       = int'((addr / 4) % (1 << ADDR_W));
    eErr  = (isLd && isSt) || (CHECK_EN && (misaligned || outOfRange));
    eIsSt = isSt && !eErr;
    eLd   = 32'd0;
    if (!eErr && isSt && !isLd) modelMem[word] = wdata;
    if (!eErr && isLd && !isSt) eLd = modelMem.exists(word) ? modelMem[word] : 32'hxxxxxxxx;
  endtask

  // One full transaction on the WAIT_CYCLES=2 instance with rsp_ready high.
  task automatic applyStimulus(input logic isLd, input logic isSt, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] gotLd,
                               output logic gotIsSt, output logic gotErr, output int lat);
    @(negedge clock);
    reqValid = 1'b1; reqIsLd = isLd; reqIsSt = isSt; reqAddr = addr; reqWdata = wdata;
    rspReady = 1'b1;
    checkOutput("reqReadyIdle", reqReady, 1'b1);
    @(posedge clock);
    #1 reqValid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (k == 1) begin
        checkOutput("reqReadyDropped", reqReady, 1'b0);
        checkOutput("busyAfterAccept", busy, 1'b1);
      end
      if (rspValid) begin
        lat = k;
        break;
      end
    end
    gotLd = rspLdResult; gotIsSt = rspIsSt; gotErr = rspError;
    if (lat < 0) begin
      nCompared++; nMismatch++;
      $display("[TB] FAIL rspTimeout: actual=no response in 40 cycles required=response");
      return;
    end
    @(negedge clock);
    checkOutput("rspValidCleared", rspValid, 1'b0);
    checkOutput("reqReadyAfterHs", reqReady, 1'b1);
    checkOutput("ldResultCleared", rspLdResult, 32'd0);
  endtask

  typedef struct {
    string       name;
    logic        isLd;
    logic        isSt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expLd;
    logic        expIsSt;
    logic        expErr;
  } vecT;

  vecT vecs [12];

  initial begin
    logic [31:0] gotLd, eLd, exp10, held;
    logic        gotIsSt, gotErr, eIsSt, eErr;
    int          lat, accepts, lastAccept, badSpacing;

    reset = 1'b1; rspReady = 1'b1; reqValid = 1'b0; reqIsLd = 1'b0; reqIsSt = 1'b0;
    reqAddr = 32'd0; reqWdata = 32'd0;
    zReqValid = 1'b0; zRspReady = 1'b1; zReqIsLd = 1'b0; zReqIsSt = 1'b0;
    zReqAddr = 32'd0; zReqWdata = 32'd0;

    // Reset held two cycles, then released.
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reqReadyInReset", reqReady, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("rstReqReady", reqReady, 1'b1);
    checkOutput("rstRspValid", rspValid, 1'b0);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstLdResult", rspLdResult, 32'd0);
    checkOutput("rstIsSt", rspIsSt, 1'b0);
    checkOutput("rstError", rspError, 1'b0);

    // Directed vectors: expected values written out from the rules.
    exp10 = CHECK_EN ? 32'hDEADBEEF : 32'hCAFEF00D;
    vecs[0]  = '{"stWord0",    1'b0, 1'b1, 32'h0000_0000, 32'hA5A5A5A5, 32'd0, 1'b1, 1'b0};
    vecs[1]  = '{"st0x10",     1'b0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 32'd0, 1'b1, 1'b0};
    vecs[2]  = '{"ld0x10",     1'b1, 1'b0, 32'h0000_0010, 32'd0, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[3]  = '{"stMisalign", 1'b0, 1'b1, 32'h0000_0013, 32'hCAFEF00D, 32'd0, !CHECK_EN, CHECK_EN};
    vecs[4]  = '{"ldAfterMis", 1'b1, 1'b0, 32'h0000_0010, 32'd0, exp10, 1'b0, 1'b0};
    vecs[5]  = '{"ldStBoth",   1'b1, 1'b1, 32'h0000_0010, 32'h77777777, 32'd0, 1'b0, 1'b1};
    vecs[6]  = '{"ldAfterBoth",1'b1, 1'b0, 32'h0000_0010, 32'd0, exp10, 1'b0, 1'b0};
    vecs[7]  = '{"noOp",       1'b0, 1'b0, 32'h0000_0010, 32'h99999999, 32'd0, 1'b0, 1'b0};
    vecs[8]  = '{"stRange",    1'b0, 1'b1, 32'h0000_1000, 32'h11112222, 32'd0, !CHECK_EN, CHECK_EN};
    vecs[9]  = '{"ldWord0",    1'b1, 1'b0, 32'h0000_0000, 32'd0,
                 CHECK_EN ? 32'hA5A5A5A5 : 32'h11112222, 1'b0, 1'b0};
    vecs[10] = '{"ldRangeWrap",1'b1, 1'b0, 32'h0000_1010, 32'd0,
                 CHECK_EN ? 32'd0 : 32'hCAFEF00D, 1'b0, CHECK_EN};
    vecs[11] = '{"ldMisalign", 1'b1, 1'b0, 32'h0000_0012, 32'd0,
                 CHECK_EN ? 32'd0 : 32'hCAFEF00D, 1'b0, CHECK_EN};

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].isLd, vecs[i].isSt, vecs[i].addr, vecs[i].wdata,
                    gotLd, gotIsSt, gotErr, lat);
      checkOutput({vecs[i].name, ".ld"}, gotLd, vecs[i].expLd);
      checkOutput({vecs[i].name, ".isSt"}, gotIsSt, vecs[i].expIsSt);
      checkOutput({vecs[i].name, ".err"}, gotErr, vecs[i].expErr);
      checkOutput({vecs[i].name, ".lat"}, lat, WAITC + 1);
    end

    // Response stall: rsp_ready low for 5 cycles while a store is offered.
    @(negedge clock);
    rspReady = 1'b0;
    reqValid = 1'b1; reqIsLd = 1'b1; reqIsSt = 1'b0; reqAddr = 32'h10; reqWdata = 32'd0;
    @(posedge clock);
    #1 reqValid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (rspValid) begin lat = k; break; end
    end
    checkOutput("stallLat", lat, WAITC + 1);
    held = rspLdResult;
    checkOutput("stallLd", held, exp10);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stallValid", rspValid, 1'b1);
      checkOutput("stallLdStable", rspLdResult, held);
      checkOutput("stallReqReady", reqReady, 1'b0);
      checkOutput("stallBusy", busy, 1'b1);
      reqValid = 1'b1; reqIsLd = 1'b0; reqIsSt = 1'b1; reqAddr = 32'h10; reqWdata = 32'hBAD0BAD0;
      @(negedge clock);
    end
    reqValid = 1'b0;
    rspReady = 1'b1;
    @(negedge clock);
    checkOutput("stallReleaseValid", rspValid, 1'b0);
    checkOutput("stallReleaseReady", reqReady, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'd0, gotLd, gotIsSt, gotErr, lat);
    checkOutput("stallIgnoredStore", gotLd, exp10);

    // Reset during WAIT (d=0) and on the RESP-entry edge (d=1).
    applyStimulus(1'b0, 1'b1, 32'h20, 32'h55AA55AA, gotLd, gotIsSt, gotErr, lat);
    for (int d = 0; d < 2; d++) begin
      @(negedge clock);
      reqValid = 1'b1; reqIsLd = 1'b0; reqIsSt = 1'b1; reqAddr = 32'h20; reqWdata = 32'h12345678;
      @(posedge clock);
      #1 reqValid = 1'b0;
      repeat (d) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("abortRspValid", rspValid, 1'b0);
      checkOutput("abortBusy", busy, 1'b0);
      checkOutput("abortReqReadyRst", reqReady, 1'b0);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clock);
        checkOutput("abortNoRsp", rspValid, 1'b0);
      end
      applyStimulus(1'b1, 1'b0, 32'h20, 32'd0, gotLd, gotIsSt, gotErr, lat);
      checkOutput("abortNoWrite", gotLd, 32'h55AA55AA);
    end

    // Randomized run against the model on words 32..47, preinitialised.
    for (int w = 0; w < 16; w++) begin
      logic [32:0] a;
      a = 33'(32'h80 + 4 * w);
      modelReq(1'b0, 1'b1, a[31:0], $urandom, eLd, eIsSt, eErr);
      applyStimulus(1'b0, 1'b1, a[31:0], modelMem[32 + w], gotLd, gotIsSt, gotErr, lat);
    end
    for (int i = 0; i < 60; i++) begin
      logic [31:0] addr, wdata;
      logic        isLd, isSt;
      int          kind, variant;
      addr    = 32'h80 + 4 * $urandom_range(0, 15);
      variant = $urandom_range(0, 9);
      if (variant == 0) addr = addr + $urandom_range(1, 3);
      if (variant == 1) addr = addr | (32'h1 << $urandom_range(12, 31));
      kind  = $urandom_range(0, 9);
      isLd  = (kind <= 3) || (kind == 9);
      isSt  = (kind >= 4 && kind <= 7) || (kind == 9);
      wdata = $urandom;
      modelReq(isLd, isSt, addr, wdata, eLd, eIsSt, eErr);
      applyStimulus(isLd, isSt, addr, wdata, gotLd, gotIsSt, gotErr, lat);
      checkOutput("rndLd", gotLd, eLd);
      checkOutput("rndIsSt", gotIsSt, eIsSt);
      checkOutput("rndErr", gotErr, eErr);
      checkOutput("rndLat", lat, WAITC + 1);
    end

    // Zero wait states: one-cycle latency, then store/load round trip.
    @(negedge clock);
    zReqValid = 1'b1; zReqIsLd = 1'b0; zReqIsSt = 1'b1; zReqAddr = 32'h8; zReqWdata = 32'h0BADF00D;
    @(posedge clock);
    #1 zReqValid = 1'b0;
    @(negedge clock);
    checkOutput("zStValid", zRspValid, 1'b1);
    checkOutput("zStIsSt", zRspIsSt, 1'b1);
    checkOutput("zStBusy", zBusy, 1'b1);
    @(negedge clock);
    checkOutput("zStCleared", zRspValid, 1'b0);
    checkOutput("zReadyBack", zReqReady, 1'b1);
    zReqValid = 1'b1; zReqIsLd = 1'b1; zReqIsSt = 1'b0; zReqAddr = 32'h8;
    @(posedge clock);
    #1 zReqValid = 1'b0;
    @(negedge clock);
    checkOutput("zLdValid", zRspValid, 1'b1);
    checkOutput("zLdData", zRspLdResult, 32'h0BADF00D);
    checkOutput("zLdErr", zRspError, 1'b0);
    @(negedge clock);

    // Back-to-back no-ops with rsp_ready high: one accept every 2 cycles.
    zReqValid = 1'b1; zReqIsLd = 1'b0; zReqIsSt = 1'b0; zReqAddr = 32'h4;
    accepts = 0; lastAccept = -1; badSpacing = 0;
    for (int c = 0; c < 12; c++) begin
      if (zReqReady) begin
        if (lastAccept >= 0 && (c - lastAccept) != 2) badSpacing++;
        lastAccept = c;
        accepts++;
      end
      @(negedge clock);
    end
    zReqValid = 1'b0;
    checkOutput("zAccepts", accepts, 6);
    checkOutput("zSpacing", badSpacing, 0);
    repeat (2) @(negedge clock);
    checkOutput("zIdle", zBusy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
